// File: rtl/constraint_sweeper_if.sv
// constraint_sweeper_if: start/done handshake, load/read ports and constraint-unit triplet for constraint_sweeper.
interface constraint_sweeper_if #(
  parameter int N_NODES = 8,
  parameter int W = 32
);
  localparam int IW = $clog2(N_NODES);
  logic start, busy, done, ld_valid, is_last;
  logic [IW-1:0] ld_idx, rd_idx;
  logic [W-1:0] ld_x, ld_y, rd_x, rd_y;
  logic [W-1:0] up_x_pos, up_y_pos, x_pos, y_pos, down_x_pos, down_y_pos;
  logic [W-1:0] x_enforced_constraints, y_enforced_constraints;
  modport master (
    output start, ld_valid, ld_idx, ld_x, ld_y, rd_idx, x_enforced_constraints, y_enforced_constraints,
    input  busy, done, rd_x, rd_y, up_x_pos, up_y_pos, x_pos, y_pos, down_x_pos, down_y_pos, is_last
  );
  modport slave (
    input  start, ld_valid, ld_idx, ld_x, ld_y, rd_idx, x_enforced_constraints, y_enforced_constraints,
    output busy, done, rd_x, rd_y, up_x_pos, up_y_pos, x_pos, y_pos, down_x_pos, down_y_pos, is_last
  );
endinterface

// File: rtl/constraint_sweeper.sv
// constraint_sweeper: Gauss-Seidel sequencer over the rope node store, feeding a combinational constraint unit.
// Option CONSTRAINT_SWEEP_BIDIR_EN: odd iterations sweep from the last node down to node 1.
module constraint_sweeper #(
  parameter int N_NODES = 8,
  parameter int ITERS = 4,
  parameter int W = 32
) (
  input logic clk,
  input logic rst_n,
  constraint_sweeper_if.slave bus
);
  localparam int IW = $clog2(N_NODES);
  localparam logic [IW-1:0] LAST = IW'(N_NODES - 1);
  localparam logic [IW-1:0] FIRST = IW'(1);
  typedef enum logic [1:0] {IDLE, PRESENT, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [7:0] iter_q, iter_d;
  logic [W-1:0] sx_q [N_NODES];
  logic [W-1:0] sy_q [N_NODES];
  logic [W-1:0] fx [N_NODES];
  logic [W-1:0] fy [N_NODES];
  logic [W-1:0] ux_q, uy_q, cx_q, cy_q, dx_q, dy_q;
  logic [IW-1:0] dn_i;
  logic last_q, dn_dir, nxt_dn, sweep_end, load_trip, wr, ld_ok;
`ifdef CONSTRAINT_SWEEP_BIDIR_EN
  assign dn_dir = iter_q[0];
  assign nxt_dn = ~iter_q[0];
`else
  assign dn_dir = 1'b0;
  assign nxt_dn = 1'b0;
`endif
  assign wr = state_q == CAPTURE;
  assign sweep_end = dn_dir ? i_q == FIRST : i_q == LAST;
  assign ld_ok = (state_q == IDLE || state_q == DONE) && bus.ld_valid && 32'(bus.ld_idx) < N_NODES;
  assign dn_i = i_d == LAST ? i_d : i_d + FIRST;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    iter_d = iter_q;
    load_trip = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = bus.start ? PRESENT : IDLE;
        load_trip = bus.start;
        i_d = bus.start ? FIRST : i_q;
        iter_d = bus.start ? 8'd0 : iter_q;
      end
      PRESENT: state_d = CAPTURE;
      default: begin
        if (!sweep_end) begin
          state_d = PRESENT;
          load_trip = 1'b1;
          i_d = dn_dir ? i_q - FIRST : i_q + FIRST;
        end else if (iter_q < 8'(ITERS - 1)) begin
          state_d = PRESENT;
          load_trip = 1'b1;
          iter_d = iter_q + 8'd1;
          i_d = nxt_dn ? LAST : FIRST;
        end else begin
          state_d = DONE;
        end
      end
    endcase
  end
  // store view with the in-flight write-back forwarded, so the next triplet sees it
  always_comb begin
    for (int k = 0; k < N_NODES; k++) begin
      fx[k] = wr && i_q == IW'(k) ? bus.x_enforced_constraints : sx_q[k];
      fy[k] = wr && i_q == IW'(k) ? bus.y_enforced_constraints : sy_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      iter_q <= '0;
      for (int k = 0; k < N_NODES; k++) begin
        sx_q[k] <= '0;
        sy_q[k] <= '0;
      end
      {ux_q, uy_q, cx_q, cy_q, dx_q, dy_q} <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      iter_q <= iter_d;
      if (wr) begin
        sx_q[i_q] <= bus.x_enforced_constraints;
        sy_q[i_q] <= bus.y_enforced_constraints;
      end else if (ld_ok) begin
        sx_q[bus.ld_idx] <= bus.ld_x;
        sy_q[bus.ld_idx] <= bus.ld_y;
      end
      if (load_trip) begin
        ux_q <= fx[i_d - FIRST];
        uy_q <= fy[i_d - FIRST];
        cx_q <= fx[i_d];
        cy_q <= fy[i_d];
        dx_q <= fx[dn_i];
        dy_q <= fy[dn_i];
        last_q <= i_d == LAST;
      end else if (state_d != PRESENT && state_d != CAPTURE) begin
        last_q <= 1'b0;
      end
    end
  end
  assign bus.busy = state_q == PRESENT || state_q == CAPTURE;
  assign bus.done = state_q == DONE;
  assign bus.rd_x = 32'(bus.rd_idx) < N_NODES ? sx_q[bus.rd_idx] : '0;
  assign bus.rd_y = 32'(bus.rd_idx) < N_NODES ? sy_q[bus.rd_idx] : '0;
  assign bus.up_x_pos = ux_q;
  assign bus.up_y_pos = uy_q;
  assign bus.x_pos = cx_q;
  assign bus.y_pos = cy_q;
  assign bus.down_x_pos = dx_q;
  assign bus.down_y_pos = dy_q;
  assign bus.is_last = last_q;
endmodule

// File: tb/tb_constraint_sweeper.sv
// tb_constraint_sweeper: scoreboard bench for constraint_sweeper with a stub constraint unit (x = up_x + 1.0, y = up_y).
module tb_constraint_sweeper;
  localparam int N = 6;
  localparam int IT = 2;
  localparam int IW = $clog2(N);
  localparam int LAT = 2 * (N - 1) * IT + 1;
`ifdef CONSTRAINT_SWEEP_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif
  typedef struct {
    logic [31:0] ux, uy, x, y, dx, dy;
    logic last;
  } trip_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mx [N];
  logic [31:0] my [N];
  trip_t exp_q [$];
  constraint_sweeper_if #(.N_NODES(N), .W(32)) bus ();
  constraint_sweeper #(.N_NODES(N), .ITERS(IT), .W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.x_enforced_constraints = bus.up_x_pos + 32'h0001_0000;
  assign bus.y_enforced_constraints = bus.up_y_pos;

  task automatic model_run();
    for (int it = 0; it < IT; it++)
      for (int s = 0; s < N - 1; s++) begin
        int i;
        trip_t t;
        i = (BIDIR && it % 2 == 1) ? N - 1 - s : 1 + s;
        t.ux = mx[i-1]; t.uy = my[i-1]; t.x = mx[i]; t.y = my[i];
        if (i == N - 1) begin t.dx = mx[i]; t.dy = my[i]; end
        else begin t.dx = mx[i+1]; t.dy = my[i+1]; end
        t.last = (i == N - 1);
        exp_q.push_back(t);
        mx[i] = mx[i-1] + 32'h0001_0000;
        my[i] = my[i-1];
      end
  endtask

  task automatic load(input int idx, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_idx = IW'(idx); bus.ld_x = x; bus.ld_y = y;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    if (idx < N) begin mx[idx] = x; my[idx] = y; end
  endtask

  // runs: back-to-back count; noise: stray start/load while busy; abort_at: cycle to assert reset (0 = never)
  task automatic run(input int runs, input bit noise, input int abort_at);
    int c, r;
    trip_t t;
    c = 0; r = 0;
    @(negedge clk);
    bus.start = 1'b1;
    model_run();
    while (1) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (noise) begin
        bus.start = (c == 3 || c == 5);
        bus.ld_valid = (c == 4); bus.ld_idx = IW'(2); bus.ld_x = 32'hdead_beef; bus.ld_y = 32'hdead_beef;
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.is_last !== 1'b0 ||
            {bus.up_x_pos, bus.up_y_pos, bus.x_pos, bus.y_pos, bus.down_x_pos, bus.down_y_pos} !== 192'd0) begin
          errors++;
          $display("FAIL abort_outputs busy=%b done=%b last=%b x_pos=%h required all zero", bus.busy, bus.done, bus.is_last, bus.x_pos);
        end
        exp_q.delete();
        for (int k = 0; k < N; k++) begin mx[k] = '0; my[k] = '0; end
        return;
      end
      if (c < LAT && c % 2 == 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL triplet_underflow cycle %0d has no expected entry", c);
        end else begin
          t = exp_q.pop_front();
          if (bus.busy !== 1'b1 || {bus.up_x_pos, bus.up_y_pos, bus.x_pos, bus.y_pos, bus.down_x_pos, bus.down_y_pos, bus.is_last}
              !== {t.ux, t.uy, t.x, t.y, t.dx, t.dy, t.last})
          begin
            errors++;
            $display("FAIL triplet c%0d got up=(%h,%h) cur=(%h,%h) dn=(%h,%h) last=%b busy=%b want up=(%h,%h) cur=(%h,%h) dn=(%h,%h) last=%b",
                     c, bus.up_x_pos, bus.up_y_pos, bus.x_pos, bus.y_pos, bus.down_x_pos, bus.down_y_pos, bus.is_last, bus.busy,
                     t.ux, t.uy, t.x, t.y, t.dx, t.dy, t.last);
          end
        end
      end else if (c < LAT) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL capture_busy c%0d busy=%b done=%b want busy=1 done=0", c, bus.busy, bus.done);
        end
      end else begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle c%0d done=%b busy=%b want done=1 busy=0", c, bus.done, bus.busy);
        end
        r++;
        if (r < runs) begin
          bus.start = 1'b1;
          model_run();
          c = 0;
        end else break;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.is_last !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b busy=%b last=%b want 0 0 0", bus.done, bus.busy, bus.is_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.is_last !== 1'b0 ||
        {bus.up_x_pos, bus.up_y_pos, bus.x_pos, bus.y_pos, bus.down_x_pos, bus.down_y_pos} !== 192'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b last=%b x_pos=%h want zeros", bus.busy, bus.done, bus.is_last, bus.x_pos);
    end
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== 32'd0 || bus.rd_y !== 32'd0) begin
        errors++;
        $display("FAIL reset_store node%0d rd=(%h,%h) want (0,0)", k, bus.rd_x, bus.rd_y);
      end
    end
  endtask

  task automatic test_build_up();
    load(0, 32'h0000_0000, 32'h000c_8000);
    for (int k = 1; k < N - 1; k++) load(k, 32'h0, 32'h0);
    load(N - 1, 32'h000c_8000, 32'h0001_44cd);
    run(1, 1'b0, 0);
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== 32'(k) * 32'h0001_0000 || bus.rd_y !== 32'h000c_8000) begin
        errors++;
        $display("FAIL build_up node%0d rd=(%h,%h) want (%h,000c8000)", k, bus.rd_x, bus.rd_y, 32'(k) * 32'h0001_0000);
      end
    end
  endtask

  task automatic test_ignored();
    load(2, 32'h0003_0000, 32'h0000_0055);
    run(1, 1'b1, 0);
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== mx[k] || bus.rd_y !== my[k]) begin
        errors++;
        $display("FAIL ignored_store node%0d rd=(%h,%h) want (%h,%h)", k, bus.rd_x, bus.rd_y, mx[k], my[k]);
      end
    end
  endtask

  task automatic test_drop();
    load(6, 32'h5555_5555, 32'h5555_5555);
    load(7, 32'h6666_6666, 32'h6666_6666);
    load(0, 32'h0002_0000, 32'h0003_0000);
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== mx[k] || bus.rd_y !== my[k]) begin
        errors++;
        $display("FAIL drop_store node%0d rd=(%h,%h) want (%h,%h)", k, bus.rd_x, bus.rd_y, mx[k], my[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run(2, 1'b0, 0);
    bus.rd_idx = '0;
    #1;
    checks++;
    if (bus.rd_x !== 32'h0002_0000 || bus.rd_y !== 32'h0003_0000) begin
      errors++;
      $display("FAIL b2b_anchor rd=(%h,%h) want (00020000,00030000)", bus.rd_x, bus.rd_y);
    end
    for (int k = 1; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== mx[k] || bus.rd_y !== my[k]) begin
        errors++;
        $display("FAIL b2b_store node%0d rd=(%h,%h) want (%h,%h)", k, bus.rd_x, bus.rd_y, mx[k], my[k]);
      end
    end
  endtask

  task automatic test_bidir();
    for (int k = 0; k < N; k++) load(k, 32'(k) * 32'h0011_0000, 32'(k) * 32'h1000 + 32'd7);
    run(1, 1'b0, 0);
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== mx[k] || bus.rd_y !== my[k]) begin
        errors++;
        $display("FAIL bidir_store node%0d rd=(%h,%h) want (%h,%h)", k, bus.rd_x, bus.rd_y, mx[k], my[k]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int dones;
    for (int k = 0; k < N; k++) load(k, 32'h0100_0000 + 32'(k), 32'h0200_0000 + 32'(k));
    run(1, 1'b0, 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = IW'(k);
      #1;
      checks++;
      if (bus.rd_x !== 32'd0 || bus.rd_y !== 32'd0) begin
        errors++;
        $display("FAIL abort_store node%0d rd=(%h,%h) want (0,0)", k, bus.rd_x, bus.rd_y);
      end
    end
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done done pulses=%0d want 0", dones);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_idx = '0; bus.ld_x = '0; bus.ld_y = '0; bus.rd_idx = '0;
    for (int k = 0; k < N; k++) begin mx[k] = '0; my[k] = '0; end
    test_reset();
    test_build_up();
    test_ignored();
    test_drop();
    test_back_to_back();
    test_bidir();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
